// File: rtl/bf_pkg.sv
// Shared definitions for the instruction sequencer blocks.
//
// Contents:
//   op_e    - request codes accepted by loop_stack_ctrl (NOP/PUSH/POP/PEEK)
//   state_e - loop_stack_ctrl FSM state encoding (IDLE/RESP)
package bf_pkg;

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_PEEK = 2'b11
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_e;

endpackage

// File: rtl/stack.sv
// Loop-address stack storage: 2**DEPTH entries of WIDTH bits.
// One synchronous write port and one combinational read port.
// Contents are deliberately not reset.
//
// Ports:
//   clk  in          - clock, rising edge
//   we   in          - write enable
//   wa   in  [DEPTH] - write address
//   wd   in  [WIDTH] - write data
//   ra   in  [DEPTH] - read address
//   rd   out [WIDTH] - read data (combinational from ra)
module stack #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             we,
    input  logic [DEPTH-1:0] wa,
    input  logic [WIDTH-1:0] wd,
    input  logic [DEPTH-1:0] ra,
    output logic [WIDTH-1:0] rd
);

    logic [WIDTH-1:0] mem [2**DEPTH];

    // Write port: one entry per cycle, no reset so the array maps onto RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wa] <= wd;
        end
    end

    assign rd = mem[ra];

endmodule

// File: rtl/loop_stack_ctrl.sv
// Push/pop controller for the loop-start address stack. Owns the stack
// pointer, drives the storage write port, and returns popped/peeked values
// through a registered valid/ready response channel. Overflow and underflow
// are flagged with sticky error bits.
//
// Ports:
//   clk, rst_n         - clock (rising edge), async active-low reset
//   op_valid/op_ready  - request handshake
//   op [2], op_data    - request code and PUSH value
//   rsp_valid/rsp_ready- response handshake
//   rsp_data, rsp_err  - popped/peeked value, underflow indication
//   level, empty, full - current occupancy
//   err_overflow       - sticky, PUSH while full
//   err_underflow      - sticky, POP/PEEK while empty
//   clr_err            - synchronous clear of both sticky bits
module loop_stack_ctrl
    import bf_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] op_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    output logic [DEPTH:0]   level,
    output logic             empty,
    output logic             full,
    output logic             err_overflow,
    output logic             err_underflow,
    input  logic             clr_err
);

    localparam logic [DEPTH:0] CAPACITY = {1'b1, {DEPTH{1'b0}}};

    state_e           state_q, state_d;
    logic [DEPTH:0]   level_q, level_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_err_q, rsp_err_d;
    logic             err_overflow_q, err_overflow_d;
    logic             err_underflow_q, err_underflow_d;

    op_e              op_code;
    logic             we;
    logic [DEPTH-1:0] ra;
    logic [WIDTH-1:0] rd;

    assign op_code = op_e'(op);

    // The read address always points at the top of stack; at level 0 it
    // wraps to the last entry, but that value is never used.
    assign ra = level_q[DEPTH-1:0] - DEPTH'(1);

    stack #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_stack (
        .clk (clk),
        .we  (we),
        .wa  (level_q[DEPTH-1:0]),
        .wd  (op_data),
        .ra  (ra),
        .rd  (rd)
    );

    assign op_ready      = (state_q == ST_IDLE);
    assign rsp_valid     = (state_q == ST_RESP);
    assign rsp_data      = rsp_data_q;
    assign rsp_err       = rsp_err_q;
    assign level         = level_q;
    assign empty         = (level_q == '0);
    assign full          = (level_q == CAPACITY);
    assign err_overflow  = err_overflow_q;
    assign err_underflow = err_underflow_q;

    // Next-state logic. The sticky bits take clr_err first so that an error
    // event later in the same cycle overrides the clear.
    always_comb begin
        state_d         = state_q;
        level_d         = level_q;
        rsp_data_d      = rsp_data_q;
        rsp_err_d       = rsp_err_q;
        err_overflow_d  = clr_err ? 1'b0 : err_overflow_q;
        err_underflow_d = clr_err ? 1'b0 : err_underflow_q;
        we              = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (op_valid) begin
                    case (op_code)
                        OP_PUSH: begin
                            if (!full) begin
                                we      = 1'b1;
                                level_d = level_q + (DEPTH+1)'(1);
                            end else begin
                                err_overflow_d = 1'b1;
                            end
                        end
                        OP_POP, OP_PEEK: begin
                            state_d = ST_RESP;
                            if (empty) begin
                                rsp_data_d      = '0;
                                rsp_err_d       = 1'b1;
                                err_underflow_d = 1'b1;
                            end else begin
                                rsp_data_d = rd;
                                rsp_err_d  = 1'b0;
                                if (op_code == OP_POP) begin
                                    level_d = level_q - (DEPTH+1)'(1);
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register; reset drops any pending response and empties the stack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            level_q         <= '0;
            rsp_data_q      <= '0;
            rsp_err_q       <= 1'b0;
            err_overflow_q  <= 1'b0;
            err_underflow_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            level_q         <= level_d;
            rsp_data_q      <= rsp_data_d;
            rsp_err_q       <= rsp_err_d;
            err_overflow_q  <= err_overflow_d;
            err_underflow_q <= err_underflow_d;
        end
    end

endmodule

// File: tb/tb_loop_stack_ctrl.sv
// Directed bench for loop_stack_ctrl (DEPTH=4, WIDTH=16).
module tb_loop_stack_ctrl;
    import bf_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        op_valid;
    logic        op_ready;
    logic [1:0]  op;
    logic [15:0] op_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic [4:0]  level;
    logic        empty;
    logic        full;
    logic        err_overflow;
    logic        err_underflow;
    logic        clr_err;

    int checks = 0;
    int errors = 0;

    loop_stack_ctrl #(.DEPTH(4), .WIDTH(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .op_valid      (op_valid),
        .op_ready      (op_ready),
        .op            (op),
        .op_data       (op_data),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_err       (rsp_err),
        .level         (level),
        .empty         (empty),
        .full          (full),
        .err_overflow  (err_overflow),
        .err_underflow (err_underflow),
        .clr_err       (clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Present one request and hold it until the accepting edge; returns #1
    // after that edge with op_valid dropped.
    task automatic issue(input logic [1:0] o, input logic [15:0] d);
        int n;
        n = 0;
        @(negedge clk);
        while (!op_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!op_ready) begin
            checks++; errors++;
            $display("[TB] FAIL issue_timeout: op_ready=%0b want 1", op_ready);
        end
        op_valid = 1'b1;
        op       = o;
        op_data  = d;
        @(posedge clk); #1;
        op_valid = 1'b0;
        op       = OP_NOP;
        op_data  = '0;
    endtask

    // Pulse clr_err for one cycle.
    task automatic pulse_clr();
        @(negedge clk);
        clr_err = 1'b1;
        @(posedge clk); #1;
        clr_err = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; op_valid = 1'b0; op = OP_NOP; op_data = '0;
        rsp_ready = 1'b1; clr_err = 1'b0;
        #12;
        checks++; if (op_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_op_ready: got %b want 1", op_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        checks++; if (rsp_data !== 16'h0000) begin errors++; $display("[TB] FAIL reset_rsp_data: got %h want 0000", rsp_data); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_err: got %b want 0", rsp_err); end
        checks++; if (level !== 5'd0 || empty !== 1'b1 || full !== 1'b0) begin errors++; $display("[TB] FAIL reset_level: got level=%0d empty=%b full=%b want 0/1/0", level, empty, full); end
        checks++; if (err_overflow !== 1'b0 || err_underflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_errs: got ovf=%b udf=%b want 0/0", err_overflow, err_underflow); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_underflow_peek();
        issue(OP_PEEK, 16'h0);
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL udf_rsp_valid: got %b want 1", rsp_valid); end
        checks++; if (rsp_err !== 1'b1 || rsp_data !== 16'h0000) begin errors++; $display("[TB] FAIL udf_rsp: got err=%b data=%h want 1/0000", rsp_err, rsp_data); end
        checks++; if (err_underflow !== 1'b1 || level !== 5'd0) begin errors++; $display("[TB] FAIL udf_flags: got udf=%b level=%0d want 1/0", err_underflow, level); end
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b0 || op_ready !== 1'b1) begin errors++; $display("[TB] FAIL udf_handshake: got valid=%b ready=%b want 0/1", rsp_valid, op_ready); end
        pulse_clr();
        checks++; if (err_underflow !== 1'b0) begin errors++; $display("[TB] FAIL udf_clear: got %b want 0", err_underflow); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp [3];
        exp[0] = 16'h0030; exp[1] = 16'h0020; exp[2] = 16'h0010;
        issue(OP_PUSH, 16'h0010);
        issue(OP_PUSH, 16'h0020);
        issue(OP_PUSH, 16'h0030);
        checks++; if (level !== 5'd3 || empty !== 1'b0) begin errors++; $display("[TB] FAIL b2b_level: got %0d empty=%b want 3/0", level, empty); end
        for (int i = 0; i < 3; i++) begin
            issue(OP_POP, 16'h0);
            checks++; if (rsp_valid !== 1'b1 || rsp_data !== exp[i] || rsp_err !== 1'b0) begin errors++; $display("[TB] FAIL b2b_pop%0d: got valid=%b data=%h err=%b want 1/%h/0", i, rsp_valid, rsp_data, rsp_err, exp[i]); end
            checks++; if (level !== 5'(2 - i)) begin errors++; $display("[TB] FAIL b2b_pop%0d_level: got %0d want %0d", i, level, 2 - i); end
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL b2b_empty: got %b want 1", empty); end
    endtask

    task automatic test_full();
        for (int i = 0; i < 16; i++) begin
            issue(OP_PUSH, 16'h0100 + 16'(i));
        end
        checks++; if (full !== 1'b1 || level !== 5'd16) begin errors++; $display("[TB] FAIL full_level: got full=%b level=%0d want 1/16", full, level); end
        checks++; if (err_overflow !== 1'b0) begin errors++; $display("[TB] FAIL full_no_ovf: got %b want 0", err_overflow); end
        issue(OP_PUSH, 16'hDEAD);
        checks++; if (err_overflow !== 1'b1 || level !== 5'd16) begin errors++; $display("[TB] FAIL ovf: got ovf=%b level=%0d want 1/16", err_overflow, level); end
        for (int i = 15; i >= 0; i--) begin
            issue(OP_POP, 16'h0);
            checks++; if (rsp_data !== 16'h0100 + 16'(i) || rsp_err !== 1'b0) begin errors++; $display("[TB] FAIL full_pop%0d: got data=%h err=%b want %h/0", i, rsp_data, rsp_err, 16'h0100 + 16'(i)); end
        end
        checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("[TB] FAIL full_drain: got empty=%b full=%b want 1/0", empty, full); end
    endtask

    task automatic test_stall();
        issue(OP_PUSH, 16'h0123);
        rsp_ready = 1'b0;
        issue(OP_PEEK, 16'h0);
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== 16'h0123 || rsp_err !== 1'b0) begin errors++; $display("[TB] FAIL stall_first: got valid=%b data=%h err=%b want 1/0123/0", rsp_valid, rsp_data, rsp_err); end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checks++; if (rsp_valid !== 1'b1 || rsp_data !== 16'h0123 || op_ready !== 1'b0) begin errors++; $display("[TB] FAIL stall_c%0d: got valid=%b data=%h ready=%b want 1/0123/0", c, rsp_valid, rsp_data, op_ready); end
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b0 || level !== 5'd1) begin errors++; $display("[TB] FAIL stall_done: got valid=%b level=%0d want 0/1", rsp_valid, level); end
        issue(OP_POP, 16'h0);
        checks++; if (rsp_data !== 16'h0123 || level !== 5'd0) begin errors++; $display("[TB] FAIL stall_pop: got data=%h level=%0d want 0123/0", rsp_data, level); end
    endtask

    task automatic test_clr_err();
        // Overflow is still set from the full test; underflow is clear.
        checks++; if (err_overflow !== 1'b1) begin errors++; $display("[TB] FAIL clr_pre_ovf: got %b want 1", err_overflow); end
        clr_err = 1'b1;
        issue(OP_POP, 16'h0);
        clr_err = 1'b0;
        checks++; if (err_underflow !== 1'b1 || rsp_err !== 1'b1) begin errors++; $display("[TB] FAIL clr_set_wins: got udf=%b rsp_err=%b want 1/1", err_underflow, rsp_err); end
        checks++; if (err_overflow !== 1'b0) begin errors++; $display("[TB] FAIL clr_ovf_cleared: got %b want 0", err_overflow); end
        @(posedge clk); #1;
        pulse_clr();
        checks++; if (err_underflow !== 1'b0 || err_overflow !== 1'b0) begin errors++; $display("[TB] FAIL clr_alone: got udf=%b ovf=%b want 0/0", err_underflow, err_overflow); end
    endtask

    task automatic test_reset_mid_response();
        issue(OP_PUSH, 16'h0055);
        rsp_ready = 1'b0;
        issue(OP_PEEK, 16'h0);
        checks++; if (rsp_valid !== 1'b1 || level !== 5'd1) begin errors++; $display("[TB] FAIL rstmid_pre: got valid=%b level=%0d want 1/1", rsp_valid, level); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0 || level !== 5'd0 || empty !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_async: got valid=%b level=%0d empty=%b want 0/0/1", rsp_valid, level, empty); end
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        issue(OP_PEEK, 16'h0);
        checks++; if (rsp_err !== 1'b1 || rsp_data !== 16'h0000 || err_underflow !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_peek: got err=%b data=%h udf=%b want 1/0000/1", rsp_err, rsp_data, err_underflow); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_underflow_peek();
        test_back_to_back();
        test_full();
        test_stall();
        test_clr_err();
        test_reset_mid_response();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
